// File: rtl/simd_issue_ctrl_pkg.sv
// Shared definitions for the SIMD issue controller: PE op-select and opcode
// encodings, FSM states and the default-width instruction layout.
package simd_issue_ctrl_pkg;

   localparam int OP_SEL_WIDTH  = 2;
   localparam int OPC_WIDTH     = 3;
   localparam int DEF_REG_AW    = 3;
   localparam int DEF_IMM_WIDTH = 16;

   typedef enum logic [OP_SEL_WIDTH-1:0] {
      OP_MOV = 2'd0,
      OP_ADD = 2'd1,
      OP_SUB = 2'd2,
      OP_MUL = 2'd3
   } pe_op_t;

   typedef enum logic [OPC_WIDTH-1:0] {
      OPC_MOV  = 3'd0,
      OPC_ADD  = 3'd1,
      OPC_SUB  = 3'd2,
      OPC_MUL  = 3'd3,
      OPC_LDI  = 3'd4,
      OPC_RDV  = 3'd5,
      OPC_NOP6 = 3'd6,
      OPC_NOP7 = 3'd7
   } simd_opc_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_OUT
   } state_t;

   typedef struct packed {
      simd_opc_t                opc;
      logic [DEF_REG_AW-1:0]    rd;
      logic [DEF_REG_AW-1:0]    ra;
      logic [DEF_REG_AW-1:0]    rb;
      logic [DEF_IMM_WIDTH-1:0] imm;
   } instr_t;

   function automatic logic is_alu(input simd_opc_t o);
      return (o inside {OPC_MOV, OPC_ADD, OPC_SUB, OPC_MUL});
   endfunction

endpackage

// File: rtl/simd_issue_ctrl_if.sv
// Instruction, PE-lane and read-out signals of the SIMD issue controller.
// master = issuer/PE-array side, slave = controller side.
interface simd_issue_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LANES  = 4,
   parameter int NUM_REGS   = 8,
   parameter int IMM_WIDTH  = 16
);
   import simd_issue_ctrl_pkg::*;

   localparam int REG_AW = $clog2(NUM_REGS);
   localparam int IW     = 3 + 3*REG_AW + IMM_WIDTH;
   localparam int VW     = NUM_LANES*DATA_WIDTH;

   logic                    instr_valid;
   logic                    instr_ready;
   logic [IW-1:0]           instr;
   logic [OP_SEL_WIDTH-1:0] pe_op;
   logic [VW-1:0]           pe_a;
   logic [VW-1:0]           pe_b;
   logic [VW-1:0]           pe_c;
   logic                    out_valid;
   logic                    out_ready;
   logic [VW-1:0]           out_data;
   logic                    busy;

   modport master (
      output instr_valid, instr, pe_c, out_ready,
      input  instr_ready, pe_op, pe_a, pe_b, out_valid, out_data, busy
   );

   modport slave (
      input  instr_valid, instr, pe_c, out_ready,
      output instr_ready, pe_op, pe_a, pe_b, out_valid, out_data, busy
   );

endinterface

// File: rtl/simd_issue_ctrl_vreg_file.sv
// Vector register file: NUM_REGS entries of NUM_LANES*DATA_WIDTH bits,
// two combinational read ports, one synchronous write port, sync clear.
module simd_vreg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LANES  = 4,
   parameter int NUM_REGS   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(NUM_REGS)-1:0]   rd_addr_a,
   output logic [NUM_LANES*DATA_WIDTH-1:0] rd_data_a,
   input  logic [$clog2(NUM_REGS)-1:0]   rd_addr_b,
   output logic [NUM_LANES*DATA_WIDTH-1:0] rd_data_b,
   input  logic                          wr_en,
   input  logic [$clog2(NUM_REGS)-1:0]   wr_addr,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] wr_data
);
   localparam int VW = NUM_LANES*DATA_WIDTH;

   logic [VW-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = regs[rd_addr_a];
   assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/simd_issue_ctrl.sv
// SIMD issue controller: decodes instructions, drives the external PE lanes
// and owns the vector register file. Optional SIMD_PERF_CNT_EN adds retired_count.
module simd_issue_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_LANES  = 4,
   parameter int NUM_REGS   = 8,
   parameter int IMM_WIDTH  = 16
) (
   input logic              clk,
   input logic              rst,
   simd_issue_ctrl_if.slave bus
`ifdef SIMD_PERF_CNT_EN
   ,
   output logic [31:0]      retired_count
`endif
);
   import simd_issue_ctrl_pkg::*;

   localparam int REG_AW = $clog2(NUM_REGS);
   localparam int IW     = 3 + 3*REG_AW + IMM_WIDTH;
   localparam int VW     = NUM_LANES*DATA_WIDTH;

   state_t state, next;
   logic   accept;

   simd_opc_t                    f_opc;
   logic [REG_AW-1:0]            f_rd, f_ra, f_rb;
   logic signed [IMM_WIDTH-1:0]  f_imm;
   logic [DATA_WIDTH-1:0]        imm_ext;

   logic [REG_AW-1:0] lat_rd, lat_ra, lat_rb;
   pe_op_t            lat_op;
   logic [VW-1:0]     out_q;

   logic [REG_AW-1:0] rf_addr_a, rf_wa;
   logic [VW-1:0]     rf_data_a, rf_data_b, rf_wd;
   logic              rf_we;

   assign f_opc   = simd_opc_t'(bus.instr[IW-1 -: 3]);
   assign f_rd    = bus.instr[IMM_WIDTH + 2*REG_AW +: REG_AW];
   assign f_ra    = bus.instr[IMM_WIDTH + REG_AW +: REG_AW];
   assign f_rb    = bus.instr[IMM_WIDTH +: REG_AW];
   assign f_imm   = bus.instr[IMM_WIDTH-1:0];
   assign imm_ext = DATA_WIDTH'(f_imm);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next;
   end

   always_comb begin
      next            = state;
      accept          = 1'b0;
      bus.instr_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.instr_ready = !rst;
            accept          = bus.instr_valid && !rst;
            if (accept) begin
               if (is_alu(f_opc))        next = ST_EXEC;
               else if (f_opc == OPC_RDV) next = ST_OUT;
            end
         end
         ST_EXEC: next = ST_IDLE;
         ST_OUT:  if (bus.out_ready) next = ST_IDLE;
         default: next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_rd <= '0;
         lat_ra <= '0;
         lat_rb <= '0;
         lat_op <= OP_MOV;
         out_q  <= '0;
      end else if (accept) begin
         lat_rd <= f_rd;
         lat_ra <= f_ra;
         lat_rb <= f_rb;
         lat_op <= pe_op_t'(f_opc[1:0]);
         if (f_opc == OPC_RDV) out_q <= rf_data_a;
      end
   end

   // Read port A serves RDV (addressed by rd) in IDLE and operand A in EXEC;
   // LDI writes at its accept edge so a following RDV sees the new value.
   assign rf_addr_a = (state == ST_EXEC) ? lat_ra : f_rd;
   assign rf_we     = (state == ST_EXEC) || (accept && f_opc == OPC_LDI);
   assign rf_wa     = (state == ST_EXEC) ? lat_rd : f_rd;
   assign rf_wd     = (state == ST_EXEC) ? bus.pe_c : {NUM_LANES{imm_ext}};

   simd_vreg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_LANES  (NUM_LANES),
      .NUM_REGS   (NUM_REGS)
   ) u_vreg (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (rf_addr_a),
      .rd_data_a (rf_data_a),
      .rd_addr_b (lat_rb),
      .rd_data_b (rf_data_b),
      .wr_en     (rf_we),
      .wr_addr   (rf_wa),
      .wr_data   (rf_wd)
   );

   assign bus.pe_op     = (state == ST_EXEC) ? lat_op : OP_MOV;
   assign bus.pe_a      = (state == ST_EXEC) ? rf_data_a : '0;
   assign bus.pe_b      = (state == ST_EXEC) ? rf_data_b : '0;
   assign bus.out_valid = (state == ST_OUT);
   assign bus.out_data  = out_q;
   assign bus.busy      = (state != ST_IDLE);

`ifdef SIMD_PERF_CNT_EN
   logic retire;
   assign retire = (state == ST_EXEC) ||
                   (state == ST_OUT && bus.out_ready) ||
                   (accept && !is_alu(f_opc) && f_opc != OPC_RDV);

   always_ff @(posedge clk) begin
      if (rst)         retired_count <= '0;
      else if (retire) retired_count <= retired_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_simd_issue_ctrl.sv
// Self-checking bench for simd_issue_ctrl with a behavioural PE-lane model;
// also checks retired_count when SIMD_PERF_CNT_EN is defined.
module tb_simd_issue_ctrl;
   import simd_issue_ctrl_pkg::*;

   localparam int DW  = 32;
   localparam int NL  = 4;
   localparam int NR  = 8;
   localparam int IMW = 16;
   localparam int VW  = NL*DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   simd_issue_ctrl_if #(.DATA_WIDTH(DW), .NUM_LANES(NL), .NUM_REGS(NR), .IMM_WIDTH(IMW)) bus ();

`ifdef SIMD_PERF_CNT_EN
   logic [31:0] retired_count;
`endif

   simd_issue_ctrl #(.DATA_WIDTH(DW), .NUM_LANES(NL), .NUM_REGS(NR), .IMM_WIDTH(IMW)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave)
`ifdef SIMD_PERF_CNT_EN
      ,
      .retired_count (retired_count)
`endif
   );

   // Purely combinational PE lanes
   always_comb begin
      bus.pe_c = '0;
      for (int l = 0; l < NL; l++) begin
         case (bus.pe_op)
            2'd0:    bus.pe_c[l*DW +: DW] = bus.pe_b[l*DW +: DW];
            2'd1:    bus.pe_c[l*DW +: DW] = bus.pe_a[l*DW +: DW] + bus.pe_b[l*DW +: DW];
            2'd2:    bus.pe_c[l*DW +: DW] = bus.pe_a[l*DW +: DW] - bus.pe_b[l*DW +: DW];
            default: bus.pe_c[l*DW +: DW] = bus.pe_a[l*DW +: DW] * bus.pe_b[l*DW +: DW];
         endcase
      end
   end

   int n_cmp   = 0;
   int n_bad   = 0;
   int exp_ret = 0;

   typedef struct {
      instr_t      ins;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic instr_t mk(input simd_opc_t o, input int rd, input int ra,
                                 input int rb, input logic [15:0] imm);
      instr_t w;
      w.opc = o;
      w.rd  = 3'(rd);
      w.ra  = 3'(ra);
      w.rb  = 3'(rb);
      w.imm = imm;
      return w;
   endfunction

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accept edge.
   task automatic send(input instr_t w);
      int n = 0;
      while (!bus.instr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.instr_ready) begin
         chk("send_timeout", 1'b0, 1'b1);
      end else begin
         bus.instr       = w;
         bus.instr_valid = 1'b1;
         @(negedge clk);
         bus.instr_valid = 1'b0;
      end
   endtask

   task automatic send_alu(input instr_t w);
      send(w);
      chk("exec_ready_low", bus.instr_ready, 1'b0);
      chk("exec_busy", bus.busy, 1'b1);
      chk("exec_pe_op", bus.pe_op, w.opc[1:0]);
      @(negedge clk);
      chk("exec_ready_back", bus.instr_ready, 1'b1);
      chk("idle_pe_op", bus.pe_op, 2'd0);
      exp_ret++;
   endtask

   task automatic do_read(input int rd, input logic [31:0] exp, input int hold);
      send(mk(OPC_RDV, rd, 0, 0, 16'h0));
      chk("rdv_valid", bus.out_valid, 1'b1);
      chk("rdv_data", bus.out_data, {NL{exp}});
      chk("rdv_pe_a_idle", bus.pe_a, '0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", bus.out_valid, 1'b1);
         chk("hold_data", bus.out_data, {NL{exp}});
         chk("hold_ready_low", bus.instr_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("rdv_valid_drop", bus.out_valid, 1'b0);
      exp_ret++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.out_ready   = 1'b0;

      tbl.push_back('{mk(OPC_LDI, 1, 0, 0, 16'd5),    32'h0});
      tbl.push_back('{mk(OPC_LDI, 2, 0, 0, 16'hFFFD), 32'h0});
      tbl.push_back('{mk(OPC_RDV, 1, 0, 0, 16'h0),    32'd5});
      tbl.push_back('{mk(OPC_RDV, 2, 0, 0, 16'h0),    32'hFFFF_FFFD});
      tbl.push_back('{mk(OPC_ADD, 3, 1, 2, 16'h0),    32'h0});
      tbl.push_back('{mk(OPC_SUB, 4, 1, 2, 16'h0),    32'h0});
      tbl.push_back('{mk(OPC_MUL, 5, 1, 2, 16'h0),    32'h0});
      tbl.push_back('{mk(OPC_RDV, 3, 0, 0, 16'h0),    32'd2});
      tbl.push_back('{mk(OPC_RDV, 4, 0, 0, 16'h0),    32'd8});
      tbl.push_back('{mk(OPC_RDV, 5, 0, 0, 16'h0),    32'hFFFF_FFF1});
      tbl.push_back('{mk(OPC_NOP6, 1, 0, 0, 16'h1234), 32'h0});
      tbl.push_back('{mk(OPC_RDV, 1, 0, 0, 16'h0),    32'd5});
      tbl.push_back('{mk(OPC_LDI, 7, 0, 0, 16'h8000), 32'h0});
      tbl.push_back('{mk(OPC_RDV, 7, 0, 0, 16'h0),    32'hFFFF_8000});
      tbl.push_back('{mk(OPC_MOV, 6, 0, 2, 16'h0),    32'h0});
      tbl.push_back('{mk(OPC_RDV, 6, 0, 0, 16'h0),    32'hFFFF_FFFD});
      tbl.push_back('{mk(OPC_SUB, 0, 2, 1, 16'h0),    32'h0});
      tbl.push_back('{mk(OPC_RDV, 0, 0, 0, 16'h0),    32'hFFFF_FFF8});
      tbl.push_back('{mk(OPC_ADD, 2, 2, 2, 16'h0),    32'h0});
      tbl.push_back('{mk(OPC_RDV, 2, 0, 0, 16'h0),    32'hFFFF_FFFA});
      tbl.push_back('{mk(OPC_NOP7, 3, 0, 0, 16'h7777), 32'h0});

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.instr_ready, 1'b0);
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_data", bus.out_data, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_pe_op", bus.pe_op, 2'd0);
      chk("rst_pe_a", bus.pe_a, '0);
      chk("rst_pe_b", bus.pe_b, '0);
`ifdef SIMD_PERF_CNT_EN
      chk("rst_retired", retired_count, '0);
`endif
      rst = 1'b0;
      #1;
      chk("post_rst_ready", bus.instr_ready, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         case (tbl[i].ins.opc)
            OPC_RDV:                     do_read(int'(tbl[i].ins.rd), tbl[i].exp, 0);
            OPC_LDI, OPC_NOP6, OPC_NOP7: begin send(tbl[i].ins); exp_ret++; end
            default:                     send_alu(tbl[i].ins);
         endcase
      end

      // Held read-out with back-pressure
      do_read(3, 32'd2, 5);

      // Wrap-around multiply
      send(mk(OPC_LDI, 1, 0, 0, 16'h7FFF));
      exp_ret++;
      send_alu(mk(OPC_MUL, 1, 1, 1, 16'h0));
      do_read(1, 32'h3FFF_0001, 0);
      send_alu(mk(OPC_MUL, 1, 1, 1, 16'h0));
      do_read(1, 32'h7FFE_0001, 0);

`ifdef SIMD_PERF_CNT_EN
      chk("retired_mid", retired_count, 32'(exp_ret));
`endif

      // Reset during EXEC aborts the write
      send(mk(OPC_ADD, 6, 1, 2, 16'h0));
      chk("abort_in_exec", bus.busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_ready_rst", bus.instr_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_ready", bus.instr_ready, 1'b1);
      chk("abort_out_data", bus.out_data, '0);
      exp_ret = 0;
      do_read(6, 32'h0, 0);

      // 3 LDI + 2 ALU + 1 RDV (above) + 1 NOP
      send(mk(OPC_LDI, 1, 0, 0, 16'd5));
      send(mk(OPC_LDI, 2, 0, 0, 16'hFFFD));
      send(mk(OPC_LDI, 3, 0, 0, 16'd1));
      exp_ret += 3;
      send_alu(mk(OPC_ADD, 4, 1, 2, 16'h0));
      send_alu(mk(OPC_SUB, 5, 1, 3, 16'h0));
      send(mk(OPC_NOP6, 0, 0, 0, 16'h0));
      exp_ret++;
      @(negedge clk);
`ifdef SIMD_PERF_CNT_EN
      chk("retired_7", retired_count, 32'd7);
      chk("retired_model", retired_count, 32'(exp_ret));
`endif
      do_read(4, 32'd2, 0);
      do_read(5, 32'd4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
